// File: rtl/sys_clk_pkg.sv
// sys_clk_pkg
//   Shared types and constants for the reset / clock-enable generator.
//   state_t    : sequencer states (WAIT_LOCK, STABLE, RST_HOLD, RUN)
//   *_CE_NUM/DEN : default enable ratios for the CPU and pixel enables
//   clog2      : ceiling log2 for sizing counters
//   cnt_width  : counter width that covers the larger of two hold times
package sys_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RST_HOLD  = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int CPU_CE_NUM = 1;
  localparam int CPU_CE_DEN = 4;
  localparam int PIX_CE_NUM = 1;
  localparam int PIX_CE_DEN = 10;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // A hold of 1 cycle needs no counting, but a zero-width vector is illegal,
  // so the counter is never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int w;
    w = clog2((a > b) ? a : b);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frac_ce_div.sv
// frac_ce_div
//   Fractional clock-enable generator: NUM strobes every DEN enabled cycles,
//   using a phase accumulator so there is no long-term drift.
//   Ports:
//     clk_sys  in  system clock
//     reset_n  in  asynchronous active-low reset
//     run      in  high while the sequencer is in RUN; low clears the phase
//     pause    in  freezes the accumulator and suppresses strobes
//     ce       out single-cycle strobe (continuous when NUM == DEN)
module frac_ce_div #(
  parameter int ACC_W = 16,
  parameter int NUM   = 1,
  parameter int DEN   = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic run,
  input  logic pause,
  output logic ce
);

  localparam logic [ACC_W:0] NUM_X = (ACC_W+1)'(NUM);
  localparam logic [ACC_W:0] DEN_X = (ACC_W+1)'(DEN);

  logic [ACC_W-1:0] r_acc;
  logic             r_ce;
  logic [ACC_W:0]   w_sum;

  // One extra bit so acc + NUM cannot wrap before the compare.
  assign w_sum = {1'b0, r_acc} + NUM_X;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_ce  <= 1'b0;
    end else if (!run) begin
      r_acc <= '0;
      r_ce  <= 1'b0;
    end else if (pause) begin
      r_ce  <= 1'b0;
    end else if (w_sum >= DEN_X) begin
      r_ce  <= 1'b1;
      r_acc <= ACC_W'(w_sum - DEN_X);
    end else begin
      r_ce  <= 1'b0;
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

  assign ce = r_ce;

endmodule

// File: rtl/sys_reset_ce_gen.sv
// sys_reset_ce_gen
//   Reset sequencer and clock-enable source sitting behind the system PLL.
//   Holds the core in reset until the PLL has been locked for LOCK_HOLD
//   cycles, then for RST_HOLD more, then releases it and runs two fractional
//   clock enables. Soft reset re-enters the hold; lock loss restarts fully.
//   Ports:
//     clk_sys    in  system clock
//     reset_n    in  asynchronous active-low reset
//     pll_locked in  PLL lock flag, asynchronous
//     soft_reset in  user reset request, level, asynchronous
//     pause      in  synchronous; freezes both clock enables
//     sys_reset  out synchronous active-high core reset
//     ready      out high while in RUN
//     ce0        out CE0_NUM/CE0_DEN strobe
//     ce1        out CE1_NUM/CE1_DEN strobe
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   WAIT_LOCK   | waiting for synchronised lock
//   STABLE      | lock seen, counting LOCK_HOLD cycles of continuous lock
//   RST_HOLD    | core reset held for RST_HOLD cycles (frozen by soft reset)
//   RUN         | core out of reset, clock enables running
module sys_reset_ce_gen
  import sys_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 1024,
  parameter int RST_HOLD    = 16,
  parameter int ACC_W       = 16,
  parameter int CE0_NUM     = CPU_CE_NUM,
  parameter int CE0_DEN     = CPU_CE_DEN,
  parameter int CE1_NUM     = PIX_CE_NUM,
  parameter int CE1_DEN     = PIX_CE_DEN
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic soft_reset,
  input  logic pause,
  output logic sys_reset,
  output logic ready,
  output logic ce0,
  output logic ce1
);

  localparam int CNT_W = cnt_width(LOCK_HOLD, RST_HOLD);
  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] RST_TC  = CNT_W'(RST_HOLD - 1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_srst_sync;
  logic                   w_lock_s;
  logic                   w_srst_s;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sys_reset;
  logic             r_ready;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_sync <= '0;
      r_srst_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
      r_srst_sync <= {r_srst_sync[SYNC_STAGES-2:0], soft_reset};
    end
  end

  assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
  assign w_srst_s = r_srst_sync[SYNC_STAGES-1];

  // Lock loss is checked first in every state, then soft reset, then the
  // terminal count, which gives the required priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!w_lock_s)             w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == LOCK_TC) w_state_nxt = ST_RST_HOLD;
      end
      ST_RST_HOLD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!w_lock_s)            w_state_nxt = ST_WAIT_LOCK;
        else if (w_srst_s)        w_cnt_nxt   = '0;
        else if (r_cnt == RST_TC) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lock_s)     w_state_nxt = ST_WAIT_LOCK;
        else if (w_srst_s) w_state_nxt = ST_RST_HOLD;
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Outputs decode the next state so they switch on the same edge that the
  // state register enters or leaves RUN, while still coming from flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sys_reset <= (w_state_nxt != ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
    end
  end

  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;

  frac_ce_div #(
    .ACC_W (ACC_W),
    .NUM   (CE0_NUM),
    .DEN   (CE0_DEN)
  ) u_ce0_div (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .run     (r_ready),
    .pause   (pause),
    .ce      (ce0)
  );

  frac_ce_div #(
    .ACC_W (ACC_W),
    .NUM   (CE1_NUM),
    .DEN   (CE1_DEN)
  ) u_ce1_div (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .run     (r_ready),
    .pause   (pause),
    .ce      (ce1)
  );

endmodule

// File: tb/tb_sys_reset_ce_gen.sv
// Directed bench for sys_reset_ce_gen with SYNC_STAGES=2, LOCK_HOLD=8,
// RST_HOLD=4, ce0 = 1/4, ce1 = 2/5. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point.
module tb_sys_reset_ce_gen;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic pll_locked;
  logic soft_reset;
  logic pause;
  logic sys_reset;
  logic ready;
  logic ce0;
  logic ce1;

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;

  sys_reset_ce_gen #(
    .SYNC_STAGES (2),
    .LOCK_HOLD   (8),
    .RST_HOLD    (4),
    .ACC_W       (16),
    .CE0_NUM     (1),
    .CE0_DEN     (4),
    .CE1_NUM     (2),
    .CE1_DEN     (5)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .pause      (pause),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .ce0        (ce0),
    .ce1        (ce1)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    ecnt++;
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, ecnt, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, ecnt, obs, exp);
    end
  endtask

  // Hand-derived phase after RUN entry at edge r: ce0 fires on r+4, r+8, ...
  // ce1 (2/5) fires on r+3, r+5, r+8, r+10, ...
  function automatic logic exp_ce0(input int e, input int r);
    return (e > r) && (((e - r - 1) % 4) == 3);
  endfunction

  function automatic logic exp_ce1(input int e, input int r);
    int k;
    k = (e - r - 1) % 5;
    return (e > r) && (k == 2 || k == 4);
  endfunction

  task automatic check_pattern(input string tag, input int r_entry, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk1({tag, "_ce0"}, ce0, exp_ce0(ecnt, r_entry));
      chk1({tag, "_ce1"}, ce1, exp_ce1(ecnt, r_entry));
    end
  endtask

  initial begin
    int base;
    int r_entry;
    int cnt0;
    int cnt1;
    int adj0;
    int adj1;
    logic prev0;
    logic prev1;

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    pause      = 1'b0;
    tick();
    tick();
    chk1("rst_sys_reset", sys_reset, 1'b1);
    chk1("rst_ready",     ready,     1'b0);
    chk1("rst_ce0",       ce0,       1'b0);
    chk1("rst_ce1",       ce1,       1'b0);

    // Power-up: locked first sampled at edge 1, RUN entered at edge 15.
    reset_n = 1'b1;
    tick();
    base = ecnt;
    pll_locked = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk1("pwrup_sys_reset_held", sys_reset, 1'b1);
      chk1("pwrup_ready_low",      ready,     1'b0);
      chk1("pwrup_ce0_idle",       ce0,       1'b0);
    end
    tick();
    chkn("pwrup_release_edge", ecnt - base, 15);
    chk1("pwrup_sys_reset_fall", sys_reset, 1'b0);
    chk1("pwrup_ready_rise",     ready,     1'b1);
    r_entry = ecnt;
    check_pattern("pwrup", r_entry, 16);

    // Fraction accuracy over 1000 RUN cycles (a multiple of both denominators).
    cnt0 = 0; cnt1 = 0; adj0 = 0; adj1 = 0;
    prev0 = ce0; prev1 = ce1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ce0) cnt0++;
      if (ce1) cnt1++;
      if (ce0 && prev0) adj0++;
      if (ce1 && prev1) adj1++;
      prev0 = ce0;
      prev1 = ce1;
    end
    chkn("frac_ce1_count",    cnt1, 400);
    chkn("frac_ce0_count",    cnt0, 250);
    chkn("frac_ce1_adjacent", adj1, 0);
    chkn("frac_ce0_adjacent", adj0, 0);
    chk1("frac_ready_held",   ready, 1'b1);

    // Pause for 7 of 27 cycles: 20 effective cycles -> 5 ce0, 8 ce1.
    cnt0 = 0; cnt1 = 0;
    for (int i = 1; i <= 27; i++) begin
      tick();
      if (ce0) cnt0++;
      if (ce1) cnt1++;
      if (i >= 11 && i <= 17) begin
        chk1("pause_ce0_zero", ce0, 1'b0);
        chk1("pause_ce1_zero", ce1, 1'b0);
      end
      if (i == 10) pause = 1'b1;
      if (i == 17) pause = 1'b0;
    end
    chkn("pause_ce0_total", cnt0, 5);
    chkn("pause_ce1_total", cnt1, 8);

    // Soft reset for 5 cycles: reset rises at +3, falls at +11.
    soft_reset = 1'b1;
    base = ecnt;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk1("srst_sys_reset", sys_reset, (k >= 3 && k <= 10));
      chk1("srst_ready",     ready,     !(k >= 3 && k <= 10));
      if (k >= 4 && k <= 11) chk1("srst_ce0_idle", ce0, 1'b0);
      if (k == 5) soft_reset = 1'b0;
    end
    r_entry = ecnt;
    check_pattern("srst", r_entry, 4);
    chk1("srst_ce0_before_async", ce0, 1'b1);

    // Async reset between edges: outputs clear with no edge.
    #2;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    #1;
    chk1("async_sys_reset", sys_reset, 1'b1);
    chk1("async_ready",     ready,     1'b0);
    chk1("async_ce0",       ce0,       1'b0);
    chk1("async_ce1",       ce1,       1'b0);
    tick();
    tick();
    chk1("async_hold_sys_reset", sys_reset, 1'b1);

    // Lock drop in STABLE: low after edge 6 for 3 samples, back after edge 9.
    reset_n = 1'b1;
    tick();
    base = ecnt;
    pll_locked = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick();
      chk1("lockdrop_sys_reset_held", sys_reset, 1'b1);
      if (k == 6) pll_locked = 1'b0;
      if (k == 9) pll_locked = 1'b1;
    end
    tick();
    chkn("lockdrop_release_edge", ecnt - base, 24);
    chk1("lockdrop_sys_reset_fall", sys_reset, 1'b0);
    chk1("lockdrop_ready_rise",     ready,     1'b1);
    r_entry = ecnt;
    check_pattern("lockdrop", r_entry, 10);

    // Lock loss in RUN returns straight to reset after the synchroniser.
    pll_locked = 1'b0;
    tick();
    tick();
    chk1("runloss_ready_pre", ready, 1'b1);
    tick();
    chk1("runloss_sys_reset", sys_reset, 1'b1);
    chk1("runloss_ready",     ready,     1'b0);
    tick();
    chk1("runloss_ce0", ce0, 1'b0);
    chk1("runloss_ce1", ce1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
